// File: rtl/fpu_wb_pkg.sv
// Purpose: shared register-file geometry, source encoding and writeback record for the FPU writeback slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_wb_pkg;

    localparam int NUM_FPU_REGS = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int FP_NUM_BITS  = 32;

    typedef enum logic [1:0] {
        SRC_ADD = 2'd0,
        SRC_MUL = 2'd1,
        SRC_DIV = 2'd2
    } fpu_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]  addr;
        logic [FP_NUM_BITS-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/fpu_wb_arbiter_if.sv
// Purpose: bundles the per-source result ports, issue tap and regfile write port of the writeback stage.
// Latency: n/a (wiring only).
// Backpressure: src_ready is the only throttle toward the execution units.
interface fpu_wb_arbiter_if #(
    parameter int num_bits = 32,
    parameter int NUM_SRC  = 3
);
    import fpu_wb_pkg::*;

    logic [NUM_SRC-1:0]                  src_valid;
    logic [NUM_SRC-1:0]                  src_ready;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_addr;
    logic [NUM_SRC-1:0][num_bits-1:0]    src_data;
    logic                                wb_stall;
    logic                                issue_valid;
    logic [REG_ADDR_W-1:0]               issue_addr;
    logic                                write_enable;
    logic [REG_ADDR_W-1:0]               write_addr;
    logic [num_bits-1:0]                 write_data;
    logic [NUM_FPU_REGS-1:0]             busy_mask;
    logic                                wb_orphan;

    // Environment side: execution units, issue stage and regfile.
    modport master (
        output src_valid, src_addr, src_data, wb_stall, issue_valid, issue_addr,
        input  src_ready, write_enable, write_addr, write_data, busy_mask, wb_orphan
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_addr, src_data, wb_stall, issue_valid, issue_addr,
        output src_ready, write_enable, write_addr, write_data, busy_mask, wb_orphan
    );

endinterface

// File: rtl/fpu_wb_arbiter_rr_arbiter.sv
// Purpose: round-robin grant among N requesters, pointer advances past the last winner.
// Latency: combinational grant; pointer updates on the granting edge.
// Backpressure: en=0 forces grant to zero and freezes the pointer.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N-1:0]                  req,
    input  logic                          en,
    output logic [N-1:0]                  grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] rr_ptr;

    always_comb begin : scan
        int         idx;
        logic       found;
        logic [IDX_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                sel = IDX_W'(idx);
                if (!found && req[sel]) begin
                    found      = 1'b1;
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Purpose: FPU writeback stage; picks one execution-unit result per cycle and tracks pending writes.
// Latency: transfer at edge N appears on write_enable/addr/data in cycle N+1; busy/orphan update each edge.
// Backpressure: no internal queue; wb_stall or reset simply withholds src_ready.
module fpu_wb_arbiter
    import fpu_wb_pkg::*;
#(
    parameter int num_bits = 32,
    parameter int NUM_SRC  = 3
) (
    input logic            clk,
    input logic            rst,
    fpu_wb_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    xfer;

    logic                    write_enable_q;
    logic [REG_ADDR_W-1:0]   write_addr_q;
    logic [num_bits-1:0]     write_data_q;
    logic [NUM_FPU_REGS-1:0] busy_q;
    logic [NUM_FPU_REGS-1:0] busy_next;
    logic                    orphan_q;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.src_valid),
        .en        (!bus.wb_stall && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.src_ready = grant;
    assign xfer          = |grant;

    // Clear first, then set: a same-cycle issue belongs to a younger op and must win.
    always_comb begin
        busy_next = busy_q;
        if (write_enable_q) begin
            busy_next[write_addr_q] = 1'b0;
        end
        if (bus.issue_valid) begin
            busy_next[bus.issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
            orphan_q       <= 1'b0;
        end else begin
            write_enable_q <= xfer;
            if (xfer) begin
                write_addr_q <= bus.src_addr[grant_idx];
                write_data_q <= bus.src_data[grant_idx];
            end
            busy_q   <= busy_next;
            orphan_q <= write_enable_q && !busy_q[write_addr_q];
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;
    assign bus.busy_mask    = busy_q;
    assign bus.wb_orphan    = orphan_q;

endmodule
